// File: rtl/ap_fifo_packet_engine.sv
// ap_fifo_packet_engine
//   User-logic stage for one 128-bit Xillybus channel, placed directly after
//   the PCIe FIFO shell. It pops framed packets (a header word followed by
//   len payload words) and applies a per-packet 32-bit lane operation. It then
//   pushes the header, the transformed payload and a checksum trailer
//   downstream. It sustains one word per cycle when neither side stalls.
//
// Ports
//   ip_clk        clock for all logic
//   ip_rst        asynchronous active-high reset
//   in_r_dout     read data from the upstream ap_fifo (valid when in_r_empty_n)
//   in_r_empty_n  upstream fifo holds a word
//   in_r_read     pop strobe (combinational)
//   out_r_din     write data to the downstream ap_fifo (registered)
//   out_r_write   push strobe, never asserted while out_r_full
//   out_r_full    downstream fifo is full
//   cfg_const     lane addend for op 1, captured when the header is accepted
//   busy          a packet is in flight or the output register holds a word
//   pkt_count     number of trailers loaded, wraps at 2^32
module ap_fifo_packet_engine #(
  parameter int DW   = 128,
  parameter int LENW = 32
) (
  input  logic          ip_clk,
  input  logic          ip_rst,
  input  logic [DW-1:0] in_r_dout,
  input  logic          in_r_empty_n,
  output logic          in_r_read,
  output logic [DW-1:0] out_r_din,
  output logic          out_r_write,
  input  logic          out_r_full,
  input  logic [31:0]   cfg_const,
  output logic          busy,
  output logic [31:0]   pkt_count
);

  localparam int LANES = DW / 32;

  typedef enum logic [1:0] {S_HDR, S_PAY, S_TRL} state_t;

  state_t            state;
  logic              out_valid;
  logic [3:0]        op;
  logic [31:0]       cfg;
  logic [LENW-1:0]   remaining;
  logic [LENW-1:0]   count;
  logic [31:0]       sum;

  logic              slot_free;
  logic [LENW-1:0]   len_in;
  logic [DW-1:0]     xform_word;
  logic [31:0]       xform_sum;
  logic              bad_op;
  logic [DW-1:0]     trailer;

  // Per-lane operation; lanes never carry into each other.
  function automatic logic [DW-1:0] lane_op(input logic [DW-1:0] w,
                                            input logic [3:0]    o,
                                            input logic [31:0]   c);
    logic [DW-1:0] r;
    r = w;
    for (int i = 0; i < LANES; i++) begin
      case (o)
        4'd1:    r[i*32 +: 32] = w[i*32 +: 32] + c;
        4'd2:    r[i*32 +: 32] = w[(LANES-1-i)*32 +: 32];
        default: r[i*32 +: 32] = w[i*32 +: 32];
      endcase
    end
    return r;
  endfunction

  function automatic logic [31:0] lane_sum(input logic [DW-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < LANES; i++) begin
      s = s + w[i*32 +: 32];
    end
    return s;
  endfunction

  // The output register may accept a new word when it is empty or is being
  // drained this cycle; out_r_write is kept out of the pop path on purpose.
  assign slot_free   = ~out_valid | ~out_r_full;
  assign out_r_write = out_valid & ~out_r_full;
  assign in_r_read   = ~ip_rst & in_r_empty_n & slot_free &
                       ((state == S_HDR) | (state == S_PAY));
  assign busy        = (state != S_HDR) | out_valid;
  assign len_in      = in_r_dout[LENW-1:0];
  assign bad_op      = (op > 4'd2);

  always_comb begin
    xform_word     = lane_op(in_r_dout, op, cfg);
    xform_sum      = lane_sum(xform_word);
    trailer        = '0;
    trailer[31:0]  = 32'(count);
    trailer[63:32] = sum;
    trailer[64]    = bad_op;
  end

  // Single-register output stage fed by the packet FSM
  always_ff @(posedge ip_clk or posedge ip_rst) begin
    if (ip_rst) begin
      state     <= S_HDR;
      out_valid <= 1'b0;
      out_r_din <= '0;
      op        <= '0;
      cfg       <= '0;
      remaining <= '0;
      count     <= '0;
      sum       <= '0;
      pkt_count <= '0;
    end else begin
      // A drain clears the slot; a load in the same cycle overrides it below.
      if (out_r_write) out_valid <= 1'b0;
      case (state)
        S_HDR: begin
          if (in_r_read) begin
            out_r_din <= in_r_dout;
            out_valid <= 1'b1;
            op        <= in_r_dout[35:32];
            cfg       <= cfg_const;
            remaining <= len_in;
            count     <= '0;
            sum       <= '0;
            state     <= (len_in != '0) ? S_PAY : S_TRL;
          end
        end
        S_PAY: begin
          if (in_r_read) begin
            out_r_din <= xform_word;
            out_valid <= 1'b1;
            sum       <= sum + xform_sum;
            count     <= count + LENW'(1);
            remaining <= remaining - LENW'(1);
            if (remaining == LENW'(1)) state <= S_TRL;
          end
        end
        S_TRL: begin
          if (slot_free) begin
            out_r_din <= trailer;
            out_valid <= 1'b1;
            pkt_count <= pkt_count + 32'd1;
            state     <= S_HDR;
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule
